pb_serial_loader: RTL



---
 rtl/pb_serial_pkg.sv | 27 ++
 rtl/pb_serial_loader_tick.sv | 33 +++
 rtl/pb_serial_loader.sv | 111 +++++++++++
 3 files changed

// File: rtl/pb_serial_pkg.sv
// Shared types and width helpers for the push-button serial loader.
// Width helpers let parameterised modules derive counter widths from their own WIDTH/DIV.
package pb_serial_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    FULL,
    SHIFT
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 4;

  // Bits needed to hold the values 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Bits needed to index 0..n-1, never less than one.
  function automatic int div_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);
  localparam int DIV_W = div_width(DEF_DIV);

endpackage

// File: rtl/pb_serial_loader_tick.sv
// DIV-clock divider for the serial bit rate.
// Emits a one-cycle tick on the last count of each bit period.
module bit_tick_gen
  import pb_serial_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            DW   = div_width(DIV);
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] cnt;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + DW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/pb_serial_loader.sv
// Button-driven word assembler: collects bits serially, then shifts the word out
// MSB first at one bit per DIV clocks. clear_pulse aborts anything in progress.
module pb_serial_loader
  import pb_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        bit0_pulse,
  input  logic                        bit1_pulse,
  input  logic                        send_pulse,
  input  logic                        clear_pulse,
  output logic [WIDTH-1:0]            word_out,
  output logic [cnt_width(WIDTH)-1:0] bit_count,
  output logic                        word_full,
  output logic                        busy,
  output logic                        ser_out,
  output logic                        ser_valid,
  output logic                        done_pulse
);

  localparam int                  CNT_BITS = cnt_width(WIDTH);
  localparam int                  IDX_BITS = div_width(WIDTH);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(WIDTH - 1);

  state_t              state;
  logic [WIDTH-1:0]    shreg;
  logic [IDX_BITS-1:0] idx;
  logic                start;
  logic                tick;

  assign start = (state == FULL) && send_pulse;

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == SHIFT),
    .clr  (clear_pulse || start),
    .tick (tick)
  );

  // shreg is zero outside SHIFT, so its MSB is the serial line directly.
  assign ser_out   = shreg[WIDTH-1];
  assign ser_valid = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      word_out   <= '0;
      bit_count  <= '0;
      shreg      <= '0;
      idx        <= '0;
      word_full  <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (clear_pulse) begin
        state     <= COLLECT;
        word_out  <= '0;
        bit_count <= '0;
        shreg     <= '0;
        idx       <= '0;
        word_full <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          COLLECT: begin
            if (bit0_pulse ^ bit1_pulse) begin
              word_out  <= {word_out[WIDTH-2:0], bit1_pulse};
              bit_count <= bit_count + CNT_BITS'(1);
              if (bit_count == LAST_CNT) begin
                state     <= FULL;
                word_full <= 1'b1;
              end
            end
          end
          FULL: begin
            if (send_pulse) begin
              shreg     <= word_out;
              idx       <= '0;
              state     <= SHIFT;
              word_full <= 1'b0;
              busy      <= 1'b1;
            end
          end
          SHIFT: begin
            if (tick) begin
              shreg <= {shreg[WIDTH-2:0], 1'b0};
              if (idx == LAST_IDX) begin
                state      <= COLLECT;
                word_out   <= '0;
                bit_count  <= '0;
                idx        <= '0;
                busy       <= 1'b0;
                done_pulse <= 1'b1;
              end else begin
                idx <= idx + IDX_BITS'(1);
              end
            end
          end
          default: state <= COLLECT;
        endcase
      end
    end
  end

endmodule
